// File: rtl/seg7_pkg.sv
// Shared types and the hex-to-segment table for the multi-digit 7-segment driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        SEG_STATIC = 2'b00,
        SEG_BLINK  = 2'b01,
        SEG_SCROLL = 2'b10,
        SEG_BLANK  = 2'b11
    } seg7_mode_t;

    // Active-low segment order {g,f,e,d,c,b,a}; all ones turns every segment off.
    localparam logic [6:0] SEG_BLANK_PAT = 7'b1111111;

    // Hex digit 0-F to active-low segment pattern.
    function automatic logic [6:0] seg7_hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_digit_decoder.sv
// Single-digit combinational hex decoder, active-low segments.
module hex_digit_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Pure table lookup; no state.
    always_comb begin
        o_seg = seg7_hex_decode(i_nibble);
    end

endmodule

// File: rtl/seg7_multi_display.sv
// N-digit hex driver: latches value/mode on load, then decodes every digit with
// optional blink, left-rotate scroll, blank and leading-zero suppression.
module seg7_multi_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int SCROLL_DIV = 12_500_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [1:0]              mode,
    input  logic                    lz_blank,
    output logic [7*NUM_DIGITS-1:0] out,
    output logic                    scroll_wrap
);

    localparam int BLINK_W  = $clog2(BLINK_DIV);
    localparam int SCROLL_W = $clog2(SCROLL_DIV);
    localparam int OFF_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [BLINK_W-1:0]  BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_DIV - 1);
    localparam logic [OFF_W-1:0]    OFF_LAST    = OFF_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] r_value;
    seg7_mode_t              r_mode;
    logic                    r_lz;
    logic [BLINK_W-1:0]      r_blink_cnt;
    logic                    r_blink_on;
    logic [SCROLL_W-1:0]     r_scroll_cnt;
    logic [OFF_W-1:0]        r_offset;
    logic                    r_scroll_wrap;

    logic [3:0]              w_sel_nib [NUM_DIGITS];
    logic [6:0]              w_dec     [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   w_lz_show;
    logic                    w_seen;
    logic                    w_lz_active;
    logic                    w_all_blank;

    // Shadow registers: captured only on the load strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= '0;
            r_mode  <= SEG_STATIC;
            r_lz    <= 1'b0;
        end else if (load) begin
            r_value <= value;
            r_mode  <= seg7_mode_t'(mode);
            r_lz    <= lz_blank;
        end
    end

    // Blink timebase: free-running except in blank mode, restarted visible on load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else if (r_mode == SEG_BLANK) begin
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Scroll timebase and rotate offset; wrap pulse marks offset N-1 -> 0.
    always_ff @(posedge clk) begin
        if (reset || load || (r_mode != SEG_SCROLL)) begin
            r_scroll_cnt  <= '0;
            r_offset      <= '0;
            r_scroll_wrap <= 1'b0;
        end else if (r_scroll_cnt == SCROLL_LAST) begin
            r_scroll_cnt  <= '0;
            r_offset      <= (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
            r_scroll_wrap <= (r_offset == OFF_LAST);
        end else begin
            r_scroll_cnt  <= r_scroll_cnt + 1'b1;
            r_scroll_wrap <= 1'b0;
        end
    end

    assign scroll_wrap = r_scroll_wrap;

    // Rotate mux: digit i takes nibble (i - offset) mod N; identity when offset is 0.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_sel_nib[i] = r_value[((i + NUM_DIGITS - int'(r_offset)) % NUM_DIGITS) * 4 +: 4];
        end
    end

    // Leading-zero mask: a digit is shown once any nibble at or above it is nonzero.
    always_comb begin
        w_seen    = 1'b0;
        w_lz_show = '1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (r_value[i*4 +: 4] != 4'h0) w_seen = 1'b1;
            w_lz_show[i] = w_seen;
        end
    end

    generate
        for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
            hex_digit_decoder u_dec (
                .i_nibble (w_sel_nib[g]),
                .o_seg    (w_dec[g])
            );
        end
    endgenerate

    // Output stage: apply blank/blink/leading-zero suppression over decoded digits.
    always_comb begin
        out         = '1;
        w_lz_active = r_lz && ((r_mode == SEG_STATIC) || (r_mode == SEG_BLINK));
        w_all_blank = (r_mode == SEG_BLANK) || ((r_mode == SEG_BLINK) && !r_blink_on);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_all_blank || (w_lz_active && !w_lz_show[i]))
                out[i*7 +: 7] = SEG_BLANK_PAT;
            else
                out[i*7 +: 7] = w_dec[i];
        end
    end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display with NUM_DIGITS=4, BLINK_DIV=4, SCROLL_DIV=3.
module tb_seg7_multi_display;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] DA = 7'b0001000;
    localparam logic [6:0] DF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;

    logic        clk;
    logic        reset;
    logic        load;
    logic [15:0] value;
    logic [1:0]  mode;
    logic        lz_blank;
    logic [27:0] out;
    logic        scroll_wrap;

    int n_cmp;
    int n_mis;
    int wraps;

    seg7_multi_display #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .SCROLL_DIV (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .value       (value),
        .mode        (mode),
        .lz_blank    (lz_blank),
        .out         (out),
        .scroll_wrap (scroll_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [1:0] m, input logic lz);
        value    = v;
        mode     = m;
        lz_blank = lz;
        load     = 1'b1;
        tick();
        load     = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        reset    = 1'b1;
        load     = 1'b0;
        value    = '0;
        mode     = 2'b00;
        lz_blank = 1'b0;

        // Reset state.
        tick();
        tick();
        check_eq("reset_out", 32'(out), 32'({4{D0}}));
        check_eq("reset_wrap", 32'(scroll_wrap), 32'd0);

        // Load while reset is high must be ignored.
        do_load(16'h12AF, 2'b00, 1'b0);
        check_eq("load_in_reset", 32'(out), 32'({4{D0}}));
        reset = 1'b0;

        // Static decode.
        do_load(16'h12AF, 2'b00, 1'b0);
        check_eq("static_12AF", 32'(out), 32'({D1, D2, DA, DF}));
        value = 16'hFFFF;
        mode  = 2'b11;
        tick();
        check_eq("no_load_hold", 32'(out), 32'({D1, D2, DA, DF}));

        // Leading-zero blanking.
        do_load(16'h0050, 2'b00, 1'b0);
        check_eq("lz_off_0050", 32'(out), 32'({D0, D0, D5, D0}));
        do_load(16'h0050, 2'b00, 1'b1);
        check_eq("lz_on_0050", 32'(out), 32'({BL, BL, D5, D0}));
        do_load(16'h0000, 2'b00, 1'b1);
        check_eq("lz_on_0000", 32'(out), 32'({BL, BL, BL, D0}));

        // Blink: 4 cycles visible, 4 blank, then visible again.
        do_load(16'h0008, 2'b01, 1'b0);
        for (int c = 0; c < 9; c++) begin
            if (c < 4 || c >= 8)
                check_eq($sformatf("blink_c%0d", c), 32'(out), 32'({D0, D0, D0, D8}));
            else
                check_eq($sformatf("blink_c%0d", c), 32'(out), 32'({BL, BL, BL, BL}));
            tick();
        end

        // Scroll: step every 3 cycles, wrap after 12.
        do_load(16'h1234, 2'b10, 1'b0);
        check_eq("scroll_off0", 32'(out), 32'({D1, D2, D3, D4}));
        wraps = 0;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (scroll_wrap) wraps++;
            if (c == 3)  check_eq("scroll_off1", 32'(out), 32'({D2, D3, D4, D1}));
            if (c == 6)  check_eq("scroll_off2", 32'(out), 32'({D3, D4, D1, D2}));
            if (c == 11) check_eq("wrap_before", 32'(scroll_wrap), 32'd0);
            if (c == 12) begin
                check_eq("scroll_back0", 32'(out), 32'({D1, D2, D3, D4}));
                check_eq("wrap_pulse", 32'(scroll_wrap), 32'd1);
            end
            if (c == 13) check_eq("wrap_after", 32'(scroll_wrap), 32'd0);
        end
        check_eq("wrap_count", 32'(wraps), 32'd1);

        // Leading-zero flag has no effect while scrolling.
        do_load(16'h0050, 2'b10, 1'b1);
        check_eq("scroll_lz_ignored", 32'(out), 32'({D0, D0, D5, D0}));

        // Reset mid-scroll wins over a simultaneous load.
        do_load(16'h1234, 2'b10, 1'b0);
        for (int c = 0; c < 6; c++) tick();
        check_eq("pre_reset_off2", 32'(out), 32'({D3, D4, D1, D2}));
        reset    = 1'b1;
        load     = 1'b1;
        value    = 16'hFFFF;
        mode     = 2'b01;
        lz_blank = 1'b1;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        check_eq("mid_reset_out", 32'(out), 32'({4{D0}}));
        check_eq("mid_reset_wrap", 32'(scroll_wrap), 32'd0);
        wraps = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (scroll_wrap) wraps++;
        end
        check_eq("post_reset_nowrap", 32'(wraps), 32'd0);
        check_eq("post_reset_out", 32'(out), 32'({4{D0}}));

        // After reset, scroll restarts from offset 0.
        do_load(16'h1234, 2'b10, 1'b0);
        check_eq("rescroll_off0", 32'(out), 32'({D1, D2, D3, D4}));

        // Blank mode stays blank.
        do_load(16'h1234, 2'b11, 1'b0);
        wraps = 0;
        for (int c = 0; c < 20; c++) begin
            if (out !== {4{BL}}) wraps++;
            if (scroll_wrap) wraps++;
            tick();
        end
        check_eq("blank_hold", 32'(wraps), 32'd0);
        check_eq("blank_out", 32'(out), 32'({4{BL}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
